dsp_sub_stream: RTL
===================

Name: dsp_sub_stream

Overview:
- Streaming, pipelined two's-complement subtractor y = a - b for the DSP lowering path.
- Runs behind a valid/ready handshake on both sides, so self-checking benches and upstream producers can issue operand pairs back-to-back and absorb backpressure.
- Holds a running count of completed results for CI pass/fail bookkeeping.
- Takes the DUT role (stimulus consumer / result producer) that test drivers talk to.

Parameters:
- WIDTH, 8, operand and result width in bits (signed two's-complement).
- LATENCY, 2, pipeline stages from input acceptance to output presentation; legal range 1..4.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0); the only reset.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- y  out  WIDTH  result.
- y_valid  out  1  result valid.
- y_ready  in  1  consumer accepts result.
- done_cnt  out  CNT_W  number of results accepted by the consumer (y_valid && y_ready).

Behaviour:
- Reset (reset==0, asynchronous): all stage valid bits 0, all data registers 0, y=0, y_valid=0, done_cnt=0. in_ready reads 1 once reset deasserts, because stage 0 is empty.
- Handshake: a transfer occurs on a rising edge where valid && ready on that side. Once y_valid is asserted, y and y_valid stay stable until y_ready.
- Pipeline: LATENCY registers, stage k holds {vld_k, data_k}. The subtraction a - b is computed at stage 0 entry. Later stages only move data.
- Stage movement rules:
  - Last stage advances (empties) when y_ready.
  - Stage k advances when stage k+1 is empty or advancing.
  - in_ready = !vld_0 || stage 0 advancing.
  - Bubbles collapse: an empty stage always accepts from the stage behind it.
- in_ready depends combinationally on y_ready. This is the only combinational in-to-out path and is allowed.
- Latency: with y_ready held 1, a pair accepted at edge N presents y_valid at edge N+LATENCY. Throughput is 1 per cycle.
- Arithmetic: result is the low WIDTH bits of the signed difference; wrap-around on overflow. Example: 8 - 33 = -25 = 8'hE7.
- Full: when all stages are valid and y_ready=0, in_ready=0. No data is lost or duplicated.
- Simultaneous output drain and input accept in the same cycle are both honoured when full, giving full-rate streaming.
- Output order equals input order, always.
- done_cnt increments by 1 per output transfer and wraps modulo 2^CNT_W.
- Reset asserted mid-operation: in-flight results are discarded, done_cnt clears, and nothing is emitted after release until a new pair is accepted.

Optional Feature:
- Macro DSP_SUB_SAT_EN.
- When defined: signed saturation instead of wrap. Overflow is detected from the WIDTH+1-bit difference.
  - Positive overflow clamps to 2^(WIDTH-1)-1.
  - Negative overflow clamps to -2^(WIDTH-1).
  - Adds output sat_flag (out, 1), travelling with y and valid only while y_valid.
- When undefined: plain wrap as above and no sat_flag port.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package dsp_pkg:
  - localparam default WIDTH and CNT_W.
  - Typedef for a pipeline stage record {vld, data, sat}.
  - Function sub_sat(a, b) returning {sat, result}, shared by the DSP add/sub family.
- One natural sub-module: dsp_pipe_stage, a single valid/ready register slice with bubble collapse, instantiated LATENCY times via generate.
- Arithmetic stays in the top.

Test Plan:
- Basic: after reset release, drive a=8, b=33, in_valid=1 for one cycle with y_ready=1 -> y_valid rises exactly LATENCY=2 cycles later with y=8'hE7 (-25); done_cnt=1.
- Wrap/saturate: a=-128, b=1 -> y=8'h7F without DSP_SUB_SAT_EN; y=8'h80 and sat_flag=1 with it. a=127, b=-1 -> 8'h80 / 8'h7F with sat_flag=1.
- Backpressure:
  - Hold y_ready=0 and offer 4 pairs (10-1, 20-2, 30-3, 40-4) -> in_ready drops after 2 accepted and y holds 9 stable.
  - Release y_ready -> outputs 9, 18, 27, 36 in order, none lost or duplicated; done_cnt=4.
- Streaming: 16 consecutive pairs with in_valid=1 and y_ready=1 -> one result per cycle after the first, in_ready never drops, done_cnt=16.
- Reset mid-flight: accept 2 pairs, pull reset low for 1 cycle before any output -> y_valid=0, y=0, done_cnt=0 immediately; no stale result appears after release.
- Counter wrap: with CNT_W=4, 17 output transfers -> done_cnt reads 1.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP add/sub streaming family: default widths,
// the pipeline stage record and the saturating subtract helper.
package dsp_pkg;

  localparam int DSP_WIDTH = 8;
  localparam int DSP_CNT_W = 16;

  // One pipeline slot as seen on the output: valid, result and overflow marker.
  typedef struct packed {
    logic                 vld;
    logic [DSP_WIDTH-1:0] data;
    logic                 sat;
  } dsp_stage_t;

  // Saturating a - b at the family default width; returns {sat, result}.
  // Overflow shows up as disagreement between the top two bits of the
  // one-bit-wider difference.
  function automatic logic [DSP_WIDTH:0] sub_sat(
    input logic signed [DSP_WIDTH-1:0] op_a,
    input logic signed [DSP_WIDTH-1:0] op_b
  );
    logic signed [DSP_WIDTH:0] diff;
    diff = {op_a[DSP_WIDTH-1], op_a} - {op_b[DSP_WIDTH-1], op_b};
    if (diff[DSP_WIDTH] != diff[DSP_WIDTH-1])
      return {1'b1, diff[DSP_WIDTH], {(DSP_WIDTH-1){~diff[DSP_WIDTH]}}};
    return {1'b0, diff[DSP_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// Single valid/ready register slice. An empty slice always loads from the
// slice behind it, so bubbles collapse and full-rate streaming is kept.
module dsp_pipe_stage #(
  parameter int PW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vld,
  input  logic [PW-1:0] i_data,
  output logic          o_rdy,
  output logic          o_vld,
  output logic [PW-1:0] o_data,
  input  logic          i_rdy
);

  logic          r_vld;
  logic [PW-1:0] r_data;

  // Slot frees up when it is empty or its content leaves this cycle.
  assign o_rdy  = !r_vld || i_rdy;
  assign o_vld  = r_vld;
  assign o_data = r_data;

  // Load the slot whenever it is free; data only changes on a real transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      if (i_vld) r_data <= i_data;
    end
  end

endmodule

// File: rtl/dsp_sub_stream.sv
// Streaming pipelined subtractor y = a - b behind valid/ready on both sides,
// with a wrapping count of delivered results.
// Optional build macro DSP_SUB_SAT_EN: signed saturation plus sat_flag output;
// without it the difference wraps and there is no sat_flag port.
module dsp_sub_stream
  import dsp_pkg::*;
#(
  parameter int WIDTH   = DSP_WIDTH,
  parameter int LATENCY = 2,
  parameter int CNT_W   = DSP_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] done_cnt
`ifdef DSP_SUB_SAT_EN
  ,
  output logic             sat_flag
`endif
);

`ifdef DSP_SUB_SAT_EN
  localparam int PW = WIDTH + 1;
`else
  localparam int PW = WIDTH;
`endif

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [PW-1:0]           w_data [0:LATENCY];
  logic                    w_vld  [0:LATENCY];
  logic                    w_rdy  [0:LATENCY];
  logic [CNT_W-1:0]        r_done_cnt;

  assign w_a_s = a;
  assign w_b_s = b;

`ifdef DSP_SUB_SAT_EN
  // Saturating difference at this instance's width; returns {sat, result}.
  function automatic logic [WIDTH:0] sat_sub(
    input logic signed [WIDTH-1:0] op_a,
    input logic signed [WIDTH-1:0] op_b
  );
    logic signed [WIDTH:0] diff;
    diff = {op_a[WIDTH-1], op_a} - {op_b[WIDTH-1], op_b};
    if (diff[WIDTH] != diff[WIDTH-1])
      return {1'b1, diff[WIDTH], {(WIDTH-1){~diff[WIDTH]}}};
    return {1'b0, diff[WIDTH-1:0]};
  endfunction

  // Stage 0 entry: saturated result with its overflow marker on top.
  assign w_data[0] = sat_sub(w_a_s, w_b_s);
`else
  // Stage 0 entry: low WIDTH bits of the difference, wrapping on overflow.
  assign w_data[0] = w_a_s - w_b_s;
`endif

  assign w_vld[0]       = in_valid;
  assign in_ready       = w_rdy[0];
  assign w_rdy[LATENCY] = y_ready;

  // LATENCY register slices; ready ripples back from the consumer.
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    dsp_pipe_stage #(.PW(PW)) u_stage (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_vld   (w_vld[k]),
      .i_data  (w_data[k]),
      .o_rdy   (w_rdy[k]),
      .o_vld   (w_vld[k+1]),
      .o_data  (w_data[k+1]),
      .i_rdy   (w_rdy[k+1])
    );
  end

  assign y       = w_data[LATENCY][WIDTH-1:0];
  assign y_valid = w_vld[LATENCY];
`ifdef DSP_SUB_SAT_EN
  assign sat_flag = w_vld[LATENCY] & w_data[LATENCY][WIDTH];
`endif

  // Count each result the consumer takes; wraps naturally at 2^CNT_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_done_cnt <= '0;
    else if (y_valid && y_ready) r_done_cnt <= r_done_cnt + 1'b1;
  end

  assign done_cnt = r_done_cnt;

endmodule
